task_dispatcher: RTL

- Parametrised task-routing engine between the AXI-MM stream FIFOs and NUM_TASKS task wrappers.
- Steers one test-vector stream to the selected task and collects that task's answer into an elastic output buffer.
- Reports byte count, answer latency, timeout and error status.
- Pulses tasks_done only after the output buffer has fully drained.

---
 rtl/task_dispatcher.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/task_dispatcher.sv
// task_dispatcher: routes one test-vector stream to the selected task channel and
// collects that task's answers into a first-word-fall-through output buffer.
// Optional feature macro: TASK_DISPATCHER_LATENCY_EN (answer-latency counter).
// When the macro is not defined, latency_cycles is tied to 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start_tests; invalid task numbers pulse bad_task_err
// FEED     | input beats forwarded to the selected task, answers accepted
// WAIT_ANS | input done, collecting answers, idle timer running
// DRAIN    | answer stream closed, waiting for the output buffer to empty
// DONE     | one-cycle tasks_done / num_bytes_out_valid pulse
module task_dispatcher #(
   parameter int NUM_TASKS      = 14,
   parameter int DIN_WIDTH      = 32,
   parameter int DOUT_WIDTH     = 32,
   parameter int OUT_FIFO_DEPTH = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            start_tests,
   input  logic [31:0]                     current_task_number,
   input  logic [NUM_TASKS-1:0]            enabled_tasks,
   input  logic [DIN_WIDTH-1:0]            in_data,
   input  logic                            in_valid,
   input  logic                            in_last,
   output logic                            in_ready,
   output logic [DIN_WIDTH-1:0]            task_data,
   output logic [NUM_TASKS-1:0]            task_data_valid,
   output logic                            task_data_first,
   output logic                            task_data_last,
   input  logic [NUM_TASKS-1:0]            task_answer_valid,
   input  logic [NUM_TASKS*DOUT_WIDTH-1:0] task_answer_data,
   input  logic [NUM_TASKS-1:0]            task_answer_last,
   output logic [DOUT_WIDTH-1:0]           out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            tasks_done,
   output logic [31:0]                     num_bytes_out,
   output logic                            num_bytes_out_valid,
   output logic [31:0]                     latency_cycles,
   output logic                            timeout_err,
   output logic                            overflow_err,
   output logic                            bad_task_err
);

   localparam int          AW         = $clog2(OUT_FIFO_DEPTH);
   localparam int          SW         = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
   localparam logic [31:0] C_BPB      = 32'(DOUT_WIDTH / 8);
   localparam logic [31:0] C_IDLE_TOP = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT_ANS, S_DRAIN, S_DONE} state_t;

   state_t                r_state;
   logic [SW-1:0]         r_sel;
   logic                  r_first;
   logic [31:0]           r_bytes;
   logic [31:0]           r_idle;
   logic                  r_timeout;
   logic                  r_overflow;
   logic                  r_bad_task;
   logic                  r_done;
   logic [DOUT_WIDTH-1:0] r_mem [OUT_FIFO_DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;

   logic                  w_task_ok;
   logic [SW-1:0]         w_new_sel;
   logic                  w_ans_valid;
   logic                  w_ans_last;
   logic [DOUT_WIDTH-1:0] w_ans_data;
   logic [NUM_TASKS-1:0]  w_tdv;
   logic                  w_in_acc;
   logic                  w_ans_acc;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;

   // Decode the requested task number against the enabled mask.
   always_comb begin
      w_task_ok = 1'b0;
      w_new_sel = '0;
      for (int k = 0; k < NUM_TASKS; k++) begin
         if (current_task_number == 32'(k + 1) && enabled_tasks[k]) begin
            w_task_ok = 1'b1;
            w_new_sel = SW'(k);
         end
      end
   end

   // Select the latched task's answer lane and steer the one-hot input valid.
   always_comb begin
      w_ans_valid = 1'b0;
      w_ans_last  = 1'b0;
      w_ans_data  = '0;
      w_tdv       = '0;
      for (int k = 0; k < NUM_TASKS; k++) begin
         if (r_sel == SW'(k)) begin
            w_ans_valid = task_answer_valid[k];
            w_ans_last  = task_answer_last[k];
            w_ans_data  = task_answer_data[k*DOUT_WIDTH +: DOUT_WIDTH];
            w_tdv[k]    = w_in_acc;
         end
      end
   end

   assign w_in_acc  = (r_state == S_FEED) & in_valid;
   assign w_ans_acc = ((r_state == S_FEED) | (r_state == S_WAIT_ANS)) & w_ans_valid;
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop     = ~w_empty & out_ready;
   // A full buffer still takes a beat when the head leaves in the same cycle.
   assign w_push    = w_ans_acc & (~w_full | w_pop);

   assign in_ready            = (r_state == S_FEED);
   assign task_data           = in_data;
   assign task_data_valid     = w_tdv;
   assign task_data_first     = w_in_acc & r_first;
   assign task_data_last      = w_in_acc & in_last;
   assign out_valid           = ~w_empty;
   assign out_data            = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign tasks_done          = r_done;
   assign num_bytes_out_valid = r_done;
   assign num_bytes_out       = r_bytes;
   assign timeout_err         = r_timeout;
   assign overflow_err        = r_overflow;
   assign bad_task_err        = r_bad_task;

   // Sequencer: run control, byte accounting, idle timer and status flags.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_first    <= 1'b0;
         r_bytes    <= '0;
         r_idle     <= '0;
         r_timeout  <= 1'b0;
         r_overflow <= 1'b0;
         r_bad_task <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_bad_task <= 1'b0;
         r_done     <= 1'b0;
         if (w_ans_acc) begin
            if (w_push) begin
               if (r_bytes > 32'hFFFF_FFFF - C_BPB) r_bytes <= 32'hFFFF_FFFF;
               else                                 r_bytes <= r_bytes + C_BPB;
            end else begin
               r_overflow <= 1'b1;
            end
         end
         case (r_state)
            S_IDLE: begin
               if (start_tests) begin
                  if (w_task_ok) begin
                     r_sel      <= w_new_sel;
                     r_first    <= 1'b1;
                     r_bytes    <= '0;
                     r_timeout  <= 1'b0;
                     r_overflow <= 1'b0;
                     r_state    <= S_FEED;
                  end else begin
                     r_bad_task <= 1'b1;
                  end
               end
            end
            S_FEED: begin
               if (w_in_acc) begin
                  r_first <= 1'b0;
                  if (in_last) begin
                     r_idle  <= C_IDLE_TOP;
                     r_state <= S_WAIT_ANS;
                  end
               end
               if (w_ans_acc && w_ans_last) r_state <= S_DRAIN;
            end
            S_WAIT_ANS: begin
               if (w_ans_acc) begin
                  r_idle <= C_IDLE_TOP;
                  if (w_ans_last) r_state <= S_DRAIN;
               end else if (r_idle == '0) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_DRAIN;
               end else begin
                  r_idle <= r_idle - 32'd1;
               end
            end
            S_DRAIN: begin
               if (w_empty) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Answer buffer pointers; the extra MSB separates full from empty.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Answer buffer storage.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_ans_data;
   end

`ifdef TASK_DISPATCHER_LATENCY_EN
   logic        r_lat_run;
   logic        r_lat_done;
   logic [31:0] r_lat_cnt;
   logic [31:0] r_latency;
   logic        w_lat_clr;

   assign w_lat_clr = (r_state == S_IDLE) & start_tests & w_task_ok;

   // Count cycles from the first input beat; capture on the first answer beat.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lat_run  <= 1'b0;
         r_lat_done <= 1'b0;
         r_lat_cnt  <= '0;
         r_latency  <= '0;
      end else if (w_lat_clr) begin
         r_lat_run  <= 1'b0;
         r_lat_done <= 1'b0;
         r_lat_cnt  <= '0;
         r_latency  <= '0;
      end else if (!r_lat_done) begin
         if (w_ans_acc) begin
            r_latency  <= r_lat_run ? r_lat_cnt : 32'd0;
            r_lat_done <= 1'b1;
            r_lat_run  <= 1'b0;
         end else if (w_in_acc && r_first) begin
            r_lat_run <= 1'b1;
            r_lat_cnt <= 32'd1;
         end else if (r_lat_run && r_lat_cnt != 32'hFFFF_FFFF) begin
            r_lat_cnt <= r_lat_cnt + 32'd1;
         end
      end
   end

   assign latency_cycles = r_latency;
`else
   assign latency_cycles = '0;
`endif

endmodule
